// File: rtl/vmicro16_apb_master_bridge_if.sv
// Bundle of the core-side request/response handshake and the APB initiator
// port driven by vmicro16_apb_master_bridge.
// - The "master" modport is the bridge's view.
// - The "slave" modport is the view of whatever sits around the bridge: the
//   core on the request side, and the interconnect/slave on the APB side.
interface vmicro16_apb_master_bridge_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
);

  // Core request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BUS_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  // Core response channel
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB initiator port towards the interconnect
  logic [BUS_WIDTH-1:0]  M_PADDR;
  logic                  M_PWRITE;
  logic                  M_PSELx;
  logic                  M_PENABLE;
  logic [DATA_WIDTH-1:0] M_PWDATA;
  logic [DATA_WIDTH-1:0] M_PRDATA;
  logic                  M_PREADY;

  // Watchdog abort pulse towards the SoC watchdog
  logic                  timeout;

  modport master (
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output M_PADDR,
    output M_PWRITE,
    output M_PSELx,
    output M_PENABLE,
    output M_PWDATA,
    input  M_PRDATA,
    input  M_PREADY,
    output timeout
  );

  modport slave (
    output req_valid,
    input  req_ready,
    output req_write,
    output req_addr,
    output req_wdata,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  M_PADDR,
    input  M_PWRITE,
    input  M_PSELx,
    input  M_PENABLE,
    input  M_PWDATA,
    output M_PRDATA,
    output M_PREADY,
    input  timeout
  );

endinterface

// File: rtl/vmicro16_apb_master_bridge.sv
// Core-side APB initiator.
// - Accepts one valid/ready load/store request at a time.
// - Runs it as a single APB transfer: SETUP for one cycle, then ACCESS.
// - Returns a one-cycle response pulse when the transfer ends.
// A stall watchdog aborts an ACCESS phase that never sees PREADY. It then
// reports an error response instead of leaving the core hung.
module vmicro16_apb_master_bridge #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic reset,
  vmicro16_apb_master_bridge_if.master bus
);

  // Watchdog counter width. Kept at least one bit so that TIMEOUT == 0,
  // which disables the watchdog, still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // The counter holds the number of wait cycles already spent in ACCESS.
  // During the TIMEOUT-th ACCESS cycle it therefore reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] ABORT_AT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic [BUS_WIDTH-1:0]  paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  timeout_q,   timeout_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  req_ready;

  // The bridge only takes a request from IDLE, and never while reset is low.
  assign req_ready = (state_q == ST_IDLE) && reset;

  // Register stage. The synchronous active-low reset clears the state, every
  // registered output and the watchdog counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the pre-edge value of its neighbours, which
    // avoids simulation races between processes.
    if (!reset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic for the IDLE -> SETUP -> ACCESS sequence.
  // The pulse outputs default low. Everything else defaults to holding.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // forgets one would otherwise infer a latch.
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (bus.req_valid && req_ready) begin
          // Address, data and direction are captured once here. They then
          // stay stable through SETUP and ACCESS.
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          pwrite_d = bus.req_write;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.M_PREADY) begin
          // Completion wins over abort, even in the last allowed cycle.
          // Read data is captured on writes as well.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.M_PRDATA;
          rsp_err_d   = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == ABORT_AT)) begin
          // The slave stalled for the whole allowance. Drop the bus and
          // return an error response with zeroed data.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          timeout_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          // Saturate rather than wrap. This only matters when the watchdog
          // is disabled and a slave stalls forever.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.M_PADDR   = paddr_q;
  assign bus.M_PWRITE  = pwrite_q;
  assign bus.M_PSELx   = psel_q;
  assign bus.M_PENABLE = penable_q;
  assign bus.M_PWDATA  = pwdata_q;
  assign bus.timeout   = timeout_q;

endmodule
